// File: rtl/uart_receiver.sv
// Oversampled 8-bit UART receiver: start/data/stop framing, error flags, sticky overrun.
// Optional even-parity bit when the macro UART_RX_PARITY_EN is defined (default build is 8N1).
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       reset,
  input  logic       budclk,
  input  logic       UART_RX,
  input  logic       rx_ack,
  output logic [7:0] RX_DATA,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_syncFill;
  logic          r_armed;
  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_parityBit;
  logic          r_parityErr;

  logic          w_rxS;
  state_t        w_stateNext;
  logic [TW-1:0] w_tickNext;
  logic [2:0]    w_bitCntNext;
  logic [7:0]    w_shiftNext;
  logic          w_parityBitNext;
  logic          w_complete;

  assign w_rxS = r_sync2;
  assign busy  = (r_state != IDLE);

  // Synchronizer flops reset to the idle level; r_syncFill tracks when they hold real line samples.
  always_ff @(posedge budclk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncFill <= 2'b00;
    end else begin
      r_sync1    <= UART_RX;
      r_sync2    <= r_sync1;
      r_syncFill <= {r_syncFill[0], 1'b1};
    end
  end

  // Reception is only armed once a genuine high line level has been seen after reset,
  // so a line that is already low at deassertion cannot start a frame.
  always_ff @(posedge budclk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (r_syncFill[1] && w_rxS) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge budclk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parityBit <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_tick      <= w_tickNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_parityBit <= w_parityBitNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_tickNext      = r_tick + TW'(1);
    w_bitCntNext    = r_bitCnt;
    w_shiftNext     = r_shift;
    w_parityBitNext = r_parityBit;
    w_complete      = 1'b0;
    case (r_state)
      IDLE: begin
        w_tickNext   = '0;
        w_bitCntNext = '0;
        if (r_armed && !w_rxS) begin
          w_stateNext = START;
        end
      end
      // A line back high at mid start bit is treated as a glitch.
      START: begin
        if (r_tick == TICK_HALF) begin
          w_tickNext  = '0;
          w_stateNext = w_rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_tick == TICK_LAST) begin
          w_tickNext   = '0;
          w_shiftNext  = {w_rxS, r_shift[7:1]};
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_stateNext = PARITY;
`else
            w_stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_tick == TICK_LAST) begin
          w_tickNext      = '0;
          w_parityBitNext = w_rxS;
          w_stateNext     = STOP;
        end
      end
`endif
      // Back to IDLE on the sampling edge so a back-to-back start bit is not missed.
      STOP: begin
        if (r_tick == TICK_LAST) begin
          w_tickNext  = '0;
          w_complete  = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_tickNext  = '0;
        w_stateNext = IDLE;
      end
    endcase
  end

  // A completion takes priority over a coinciding acknowledge.
  always_ff @(posedge budclk or posedge reset) begin
    if (reset) begin
      RX_DATA     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      r_parityErr <= 1'b0;
    end else if (w_complete) begin
      RX_DATA     <= r_shift;
      rx_valid    <= 1'b1;
      frame_err   <= ~w_rxS;
      r_parityErr <= ^{r_shift, r_parityBit};
      if (rx_valid && !rx_ack) begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parityErr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expectations, a monitor pops
// and checks them whenever the receiver presents a new byte.
module tb_uart_receiver;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int EXP_LAT = (9 + P) * OS + OS / 2 + 2;

  logic       reset;
  logic       budclk;
  logic       UART_RX;
  logic       rx_ack;
  logic [7:0] RX_DATA;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
    int         startCycle;
    int         id;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   pushCount   = 0;
  int   popCount    = 0;
  int   cycleCnt    = 0;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .reset     (reset),
    .budclk    (budclk),
    .UART_RX   (UART_RX),
    .rx_ack    (rx_ack),
    .RX_DATA   (RX_DATA),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial budclk = 1'b0;
  always #5 budclk = ~budclk;

  always @(posedge budclk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    UART_RX = b;
    repeat (OS) @(negedge budclk);
  endtask

  // Pushes the expected result, then drives one full frame starting at the current negedge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityBit,
                               input logic expFe, input logic expPe, input logic expOv);
    exp_t e;
    e.data       = data;
    e.fe         = expFe;
    e.pe         = expPe;
    e.ov         = expOv;
    e.startCycle = cycleCnt;
    e.id         = pushCount;
    expQ.push_back(e);
    pushCount++;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef UART_RX_PARITY_EN
    sendBit(parityBit);
`else
    if (parityBit === 1'bx) UART_RX = 1'b1;
`endif
    sendBit(stopBit);
    UART_RX = 1'b1;
  endtask

  task automatic waitPops(input string name);
    int n;
    n = 0;
    while (popCount < pushCount && n < 4 * OS) begin
      @(negedge budclk);
      n++;
    end
    testsRun++;
    if (popCount < pushCount) begin
      testsFailed++;
      $display("[TB] FAIL %s_timeout: outputs seen %0d, expected %0d", name, popCount, pushCount);
    end
  endtask

  task automatic ackPulse();
    rx_ack = 1'b1;
    @(negedge budclk);
    rx_ack = 1'b0;
  endtask

  // Monitor: a new byte is presented when rx_valid rises or the output byte/flags change.
  initial begin
    logic       prevValid, prevFe, prevPe, prevOv, prevReset;
    logic [7:0] prevData;
    exp_t       e;
    int         lat;
    prevValid = 1'b0; prevFe = 1'b0; prevPe = 1'b0; prevOv = 1'b0;
    prevReset = 1'b1; prevData = 8'h00;
    forever begin
      @(negedge budclk);
      #1;
      if (!reset && !prevReset &&
          ((rx_valid && !prevValid) || RX_DATA !== prevData || frame_err !== prevFe ||
           parity_err !== prevPe || (overrun && !prevOv))) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_output: got RX_DATA=0x%0h, expected no output", RX_DATA);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("frame%0d_data", e.id), RX_DATA, e.data);
          checkOutput($sformatf("frame%0d_valid", e.id), rx_valid, 1);
          checkOutput($sformatf("frame%0d_frame_err", e.id), frame_err, e.fe);
          checkOutput($sformatf("frame%0d_parity_err", e.id), parity_err, e.pe);
          checkOutput($sformatf("frame%0d_overrun", e.id), overrun, e.ov);
          checkOutput($sformatf("frame%0d_busy", e.id), busy, 0);
          lat = cycleCnt - e.startCycle;
          testsRun++;
          if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
            testsFailed++;
            $display("[TB] FAIL frame%0d_latency: got %0d cycles, expected %0d +/-1", e.id, lat, EXP_LAT);
          end
          popCount++;
        end
      end
      prevValid = rx_valid; prevFe = frame_err; prevPe = parity_err;
      prevOv = overrun; prevData = RX_DATA; prevReset = reset;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; UART_RX = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge budclk);
    checkOutput("reset_data", RX_DATA, 8'h00);
    checkOutput("reset_valid", rx_valid, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_parity_err", parity_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;
    repeat (OS) @(negedge budclk);

    // Plain frame, then acknowledge; a stray ack while empty must do nothing.
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitPops("a5");
    checkOutput("a5_valid_held", rx_valid, 1);
    ackPulse();
    checkOutput("a5_ack_clears", rx_valid, 0);
    ackPulse();
    @(negedge budclk);
    checkOutput("idle_ack_valid", rx_valid, 0);
    checkOutput("idle_ack_overrun", overrun, 0);

    // Five-cycle low glitch.
    UART_RX = 1'b0;
    repeat (5) @(negedge budclk);
    checkOutput("glitch_busy_start", busy, 1);
    UART_RX = 1'b1;
    repeat (2 * OS) @(negedge budclk);
    checkOutput("glitch_busy_end", busy, 0);
    checkOutput("glitch_valid", rx_valid, 0);
    checkOutput("glitch_data", RX_DATA, 8'hA5);

    // Stop bit low.
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2 * OS) @(negedge budclk);
    waitPops("3c");
    ackPulse();
    checkOutput("3c_ack_clears", rx_valid, 0);

    // Back-to-back frames with no acknowledge.
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    waitPops("b2b");
    checkOutput("b2b_valid", rx_valid, 1);
    ackPulse();
    checkOutput("b2b_ack_clears", rx_valid, 0);
    checkOutput("b2b_overrun_sticky", overrun, 1);

    // Reset during data bit 4 of 8'h0F, line held low through deassertion.
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    UART_RX = 1'b0;
    repeat (OS / 2) @(negedge budclk);
    reset = 1'b1;
    repeat (2) @(negedge budclk);
    checkOutput("midreset_data", RX_DATA, 8'h00);
    checkOutput("midreset_valid", rx_valid, 0);
    checkOutput("midreset_frame_err", frame_err, 0);
    checkOutput("midreset_overrun", overrun, 0);
    checkOutput("midreset_busy", busy, 0);
    reset = 1'b0;
    repeat (3 * OS) @(negedge budclk);
    checkOutput("low_after_reset_busy", busy, 0);
    checkOutput("low_after_reset_valid", rx_valid, 0);
    UART_RX = 1'b1;
    repeat (2 * OS) @(negedge budclk);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitPops("ff");
    ackPulse();

`ifdef UART_RX_PARITY_EN
    // 8'h07 has three ones: even parity requires a 1.
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    waitPops("par_bad");
    ackPulse();
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    waitPops("par_good");
    ackPulse();
`endif

    repeat (OS) @(negedge budclk);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: budclk ticks per bit, even, range 8..32.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port budclk, input, 1 bit: oversampling clock running at OVERSAMPLE x baud rate; all logic is on its rising edge.
REQ-004 SHALL have port UART_RX, input, 1 bit: serial line, asynchronous to budclk, idle high.
REQ-005 SHALL have port rx_ack, input, 1 bit: consumer acknowledge that clears rx_valid.
REQ-006 SHALL have port RX_DATA, output, 8 bits: last received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: byte available, held until acknowledged.
REQ-008 SHALL have port frame_err, output, 1 bit: stop bit sampled low on the byte in RX_DATA.
REQ-009 SHALL have port parity_err, output, 1 bit: parity mismatch on the byte in RX_DATA; tied 0 when parity is compiled out.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, a frame completed while rx_valid was still high.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL pass UART_RX through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY and STOP with a tick counter (width clog2(OVERSAMPLE)) and a bit counter (3 bits).
REQ-014 SHALL, in IDLE, move to START with the tick counter cleared on the first cycle rx_s=0.
REQ-015 SHALL, in START, sample at tick OVERSAMPLE/2-1; rx_s=0 -> DATA with the tick counter cleared; rx_s=1 -> IDLE as a glitch, with no flags and no output change.
REQ-016 SHALL, in DATA, sample at tick OVERSAMPLE-1 (mid-bit) and shift LSB first; after bit 7 go to PARITY if compiled in, else STOP.
REQ-017 SHALL, in STOP, sample at tick OVERSAMPLE-1, then return to IDLE on the same edge so a back-to-back start bit is detected.
REQ-018 SHALL, on the stop-sample edge, load RX_DATA, set rx_valid=1, and load frame_err=~rx_s and parity_err; both error flags describe the current RX_DATA only.
REQ-019 SHALL, on the stop-sample edge, set overrun=1 if rx_valid was already 1 and rx_ack=0 on that edge; the new byte still overwrites RX_DATA.
REQ-020 SHALL clear rx_valid on the edge following rx_ack=1; if rx_ack and a completion coincide, completion wins: rx_valid stays 1 and overrun is not set.
REQ-021 SHALL clear overrun only by reset.
REQ-022 SHALL ignore rx_ack while rx_valid=0.
REQ-023 SHALL have a latency from the start-bit falling edge at UART_RX to rx_valid=1 of (9 + P) x OVERSAMPLE + OVERSAMPLE/2 + 2 budclk cycles (+/-1), where P=1 with parity and 0 without.

Reset
REQ-024 SHALL, on reset assertion, immediately force state=IDLE, all counters=0, synchronizer flops=1, RX_DATA=8'h00, and rx_valid, frame_err, parity_err, overrun and busy=0.
REQ-025 SHALL abort a frame when reset is asserted mid-frame, with no output update.
REQ-026 SHALL require a new falling edge after reset deassertion before reception starts, even if the line is low at deassertion.

Configuration
REQ-027 SHALL use macro UART_RX_PARITY_EN: when defined, the PARITY state samples one even-parity bit mid-bit, and parity_err = XOR(data bits, parity bit).
REQ-028 SHALL, when UART_RX_PARITY_EN is undefined, omit PARITY (DATA goes directly to STOP) and tie parity_err to 0; the frame is 8N1.

Verification
REQ-029 SHALL cover an 8N1 frame of 8'hA5 with OVERSAMPLE=16 -> RX_DATA=8'hA5, rx_valid=1, frame_err=0; rx_ack pulse -> rx_valid=0 on the next edge.
REQ-030 SHALL cover a 5-tick low glitch on UART_RX -> returns to IDLE, rx_valid stays 0, RX_DATA unchanged.
REQ-031 SHALL cover a frame of 8'h3C with the stop bit low -> RX_DATA=8'h3C, rx_valid=1, frame_err=1.
REQ-032 SHALL cover two back-to-back frames 8'h01 then 8'h02 with no ack -> RX_DATA=8'h02, overrun=1; rx_ack then clears rx_valid while overrun stays 1.
REQ-033 SHALL cover reset pulsed during data bit 4 -> all outputs 0, busy=0; a following frame of 8'hFF is received correctly.
REQ-034 SHALL cover, with UART_RX_PARITY_EN defined, 8'h07 sent with parity bit 0 -> parity_err=1; resent with parity bit 1 -> parity_err=0.
